// File: rtl/apb_rw_arbiter.sv
// Shares the bridge's single APB engine between the write and read paths.
// One whole burst is granted at a time, round-robin when contested, with a grant watchdog.
module apb_rw_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_req_i,
    input  logic rd_req_i,
    input  logic done_i,
    output logic grant_wr_o,
    output logic grant_rd_o,
    output logic busy_o,
    output logic timeout_o,
    output logic last_wr_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_WR = 2'd1,
        GNT_RD = 2'd2
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] wdog;
    logic        last_wr;
    logic        timeout_q;
    logic        grant_entry;
    logic        pick_wr;
    logic        timeout_nxt;
    logic        expire;

    // done_i takes priority over the watchdog in the same cycle
    assign expire = (wdog == WD_LAST) && !done_i;

    always_comb begin
        state_nxt   = state;
        grant_entry = 1'b0;
        pick_wr     = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req_i && rd_req_i) begin
                    pick_wr = !last_wr;
                end else begin
                    pick_wr = wr_req_i;
                end
                if (wr_req_i || rd_req_i) begin
                    grant_entry = 1'b1;
                    state_nxt   = pick_wr ? GNT_WR : GNT_RD;
                end
            end
            GNT_WR, GNT_RD: begin
                if (done_i) begin
                    state_nxt = IDLE;
                end else if (expire) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wdog      <= 16'd0;
            last_wr   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            timeout_q <= timeout_nxt;
            if (grant_entry) begin
                wdog    <= 16'd0;
                last_wr <= pick_wr;
            end else if (state != IDLE) begin
                wdog <= wdog + 16'd1;
            end
        end
    end

    // Grants decode straight from the state register so reset drops them at once
    assign grant_wr_o = (state == GNT_WR);
    assign grant_rd_o = (state == GNT_RD);
    assign busy_o     = (state != IDLE);
    assign timeout_o  = timeout_q;
    assign last_wr_o  = last_wr;

endmodule

// File: tb/tb_apb_rw_arbiter.sv
// Randomized and directed bench for apb_rw_arbiter against a cycle-level ownership model.
module tb_apb_rw_arbiter;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_req = 1'b0;
    logic rd_req = 1'b0;
    logic done = 1'b0;
    logic grant_wr_o, grant_rd_o, busy_o, timeout_o, last_wr_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the engine, how many grant cycles have elapsed, last direction, pulse
    int m_own  = 0;   // 0 none, 1 write, 2 read
    int m_held = 0;
    bit m_last = 1'b0;
    bit m_to   = 1'b0;

    apb_rw_arbiter #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req_i   (wr_req),
        .rd_req_i   (rd_req),
        .done_i     (done),
        .grant_wr_o (grant_wr_o),
        .grant_rd_o (grant_rd_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o),
        .last_wr_o  (last_wr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own  = 0;
        m_held = 0;
        m_last = 1'b0;
        m_to   = 1'b0;
    endtask

    task automatic model_update();
        bit to_new;
        bit dir;
        to_new = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_own == 0) begin
            if (wr_req || rd_req) begin
                dir    = (wr_req && rd_req) ? !m_last : wr_req;
                m_own  = dir ? 1 : 2;
                m_last = dir;
                m_held = 1;
            end
        end else if (done) begin
            m_own = 0;
        end else if (m_held == TMO) begin
            m_own  = 0;
            to_new = 1'b1;
        end else begin
            m_held++;
        end
        m_to = to_new;
    endtask

    task automatic compare_all();
        chk("grant_wr", grant_wr_o, (m_own == 1));
        chk("grant_rd", grant_rd_o, (m_own == 2));
        chk("busy",     busy_o,     (m_own != 0));
        chk("timeout",  timeout_o,  m_to);
        chk("last_wr",  last_wr_o,  m_last);
        chk("mutex",    grant_wr_o & grant_rd_o, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int gcount;
        int idle_run;
        bit prev_busy;
        bit exp_dir;
        int ngrants;

        // Reset state, then a quiet idle period
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Single write burst, done in grant cycle 4
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        gcount = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            gcount += grant_wr_o;
        end
        chk("wr_len", gcount, 4);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("wr_released", grant_wr_o, 1'b0);
        chk("wr_last", last_wr_o, 1'b1);
        step();

        // Both pending: grants must alternate with exactly one idle cycle between
        wr_req = 1'b1;
        rd_req = 1'b1;
        prev_busy = 1'b0;
        exp_dir = !last_wr_o;
        idle_run = 0;
        ngrants = 0;
        for (int i = 0; i < 20; i++) begin
            done = (m_own != 0 && m_held == 3);
            step();
            if (busy_o && !prev_busy) begin
                chk("rr_dir", grant_wr_o, exp_dir);
                if (ngrants > 0) chk("rr_gap", idle_run, 1);
                exp_dir = !exp_dir;
                ngrants++;
                idle_run = 0;
            end else if (!busy_o) begin
                idle_run++;
            end
            prev_busy = busy_o;
        end
        chk("rr_count", ngrants, 5);
        wr_req = 1'b0;
        rd_req = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Watchdog: read held with no done lasts exactly TMO cycles, then one timeout pulse
        rd_req = 1'b1;
        step();
        gcount = 0;
        for (int i = 0; i < TMO + 1; i++) begin
            gcount += grant_rd_o;
            if (i < TMO) chk("wd_no_pulse", timeout_o, 1'b0);
            else chk("wd_pulse", timeout_o, 1'b1);
            if (i < TMO) step();
        end
        chk("wd_len", gcount, TMO);
        rd_req = 1'b0;
        step();
        chk("wd_pulse_once", timeout_o, 1'b0);
        for (int i = 0; i < TMO + 2; i++) step();

        // done exactly on the expiry cycle: normal release, no pulse
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            done = (m_own != 0 && m_held == TMO);
            step();
        end
        done = 1'b0;
        chk("edge_released", busy_o, 1'b0);
        chk("edge_no_pulse", timeout_o, 1'b0);
        step();
        chk("edge_no_pulse2", timeout_o, 1'b0);

        // Reset in the middle of a write grant drops outputs without a clock edge
        wr_req = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_gnt_wr", grant_wr_o, 1'b0);
        chk("async_busy", busy_o, 1'b0);
        chk("async_last", last_wr_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_req = 1'b1;
        step();
        chk("post_rst_wr_first", grant_wr_o, 1'b1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;

        // Random traffic, including done pulses while idle
        for (int i = 0; i < 400; i++) begin
            wr_req = 1'($urandom_range(0, 1));
            rd_req = 1'($urandom_range(0, 1));
            done   = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
